// File: rtl/ps2_tx_if.sv
// Host-side command interface of the PS/2 transmitter: start strobe, command byte, status ticks.
interface ps2_tx_if;
  logic       wr_ps2;
  logic [7:0] din;
  logic       tx_idle;
  logic       tx_done_tick;
  logic       tx_err_tick;

  modport master (output wr_ps2, din, input tx_idle, tx_done_tick, tx_err_tick);
  modport slave  (input wr_ps2, din, output tx_idle, tx_done_tick, tx_err_tick);
endinterface

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, 11-bit frame on device clock, ack check.
// Optional watchdog abort is enabled with `define PS2_TX_TIMEOUT_EN.
module ps2_tx #(
  parameter int unsigned INHIBIT_CYCLES = 6000,
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic     clk,
  input  logic     reset,
  ps2_tx_if.slave  bus,
  inout  wire      ps2c,
  inout  wire      ps2d
);
  // One counter serves both the inhibit delay and the watchdog; they never overlap in time.
  localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, RTS, START, DATA, STOP, ACK, WAIT_REL} state_t;

  state_t                state;
  logic [FILTER_LEN-1:0] filt;
  logic                  c_lvl;
  logic                  c_next;
  logic                  fall_edge;
  logic [1:0]            d_sync;
  logic [8:0]            frame;
  logic [3:0]            bcnt;
  logic [CW-1:0]         cnt;
  logic                  c_en;
  logic                  d_en;

  assign ps2c = c_en ? 1'b0 : 1'bz;
  assign ps2d = d_en ? 1'b0 : 1'bz;

  always_comb begin
    c_next = c_lvl;
    if (&filt)
      c_next = 1'b1;
    else if (~|filt)
      c_next = 1'b0;
  end

  assign fall_edge = c_lvl & ~c_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt   <= '1;
      c_lvl  <= 1'b1;
      d_sync <= '1;
    end else begin
      filt   <= {ps2c, filt[FILTER_LEN-1:1]};
      c_lvl  <= c_next;
      d_sync <= {d_sync[0], ps2d};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      frame            <= '0;
      bcnt             <= '0;
      cnt              <= '0;
      c_en             <= 1'b0;
      d_en             <= 1'b0;
      bus.tx_idle      <= 1'b1;
      bus.tx_done_tick <= 1'b0;
      bus.tx_err_tick  <= 1'b0;
    end else begin
      bus.tx_done_tick <= 1'b0;
      bus.tx_err_tick  <= 1'b0;
      unique case (state)
        IDLE: begin
          // an abort tick lands in the first IDLE cycle; keep it apart from acceptance
          if (bus.wr_ps2 && !bus.tx_err_tick) begin
            frame       <= {~^bus.din, bus.din};
            cnt         <= CW'(INHIBIT_CYCLES - 1);
            c_en        <= 1'b1;
            d_en        <= 1'b0;
            bus.tx_idle <= 1'b0;
            state       <= RTS;
          end
        end
        RTS: begin
          if (cnt == '0) begin
            c_en  <= 1'b0;
            d_en  <= 1'b1;
            cnt   <= CW'(TIMEOUT_CYCLES);
            state <= START;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        START: begin
          if (fall_edge) begin
            bcnt  <= 4'd8;
            d_en  <= ~frame[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (fall_edge) begin
            frame <= frame >> 1;
            if (bcnt == 4'd0) begin
              d_en  <= 1'b0;
              state <= STOP;
            end else begin
              d_en <= ~frame[1];
              bcnt <= bcnt - 4'd1;
            end
          end
        end
        STOP: begin
          if (fall_edge)
            state <= ACK;
        end
        ACK: begin
          if (fall_edge) begin
            if (d_sync[1])
              bus.tx_err_tick <= 1'b1;
            else
              bus.tx_done_tick <= 1'b1;
            state <= WAIT_REL;
          end
        end
        WAIT_REL: begin
          if (c_lvl && d_sync[1]) begin
            bus.tx_idle <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
`ifdef PS2_TX_TIMEOUT_EN
      // watchdog overrides the state decode above when it expires
      if (state inside {START, DATA, STOP, ACK, WAIT_REL}) begin
        if (fall_edge && state != WAIT_REL) begin
          cnt <= CW'(TIMEOUT_CYCLES);
        end else if (cnt == '0) begin
          c_en             <= 1'b0;
          d_en             <= 1'b0;
          bus.tx_idle      <= 1'b1;
          bus.tx_done_tick <= 1'b0;
          bus.tx_err_tick  <= 1'b1;
          state            <= IDLE;
        end else begin
          cnt <= cnt - CW'(1);
        end
      end
`endif
    end
  end
endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: device model clocks frames out, checks against a parity/frame reference.
module tb_ps2_tx;
  localparam int INH  = 600;
  localparam int TMO  = 3000;
  localparam int HALF = 40;

  typedef struct {
    logic [7:0] din;
    bit         ack;
    bit         glitch;
    bit         par;
    bit         exp_done;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ps2_tx_if bus();
  wire  ps2c;
  wire  ps2d;
  logic dev_c_low = 1'b0;
  logic dev_d_low = 1'b0;

  pullup (ps2c);
  pullup (ps2d);
  assign ps2c = dev_c_low ? 1'b0 : 1'bz;
  assign ps2d = dev_d_low ? 1'b0 : 1'bz;

  ps2_tx #(.INHIBIT_CYCLES(INH), .FILTER_LEN(8), .TIMEOUT_CYCLES(TMO)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .ps2c (ps2c),
    .ps2d (ps2d)
  );

  int tests = 0;
  int fails = 0;
  int n_done = 0;
  int n_err = 0;
  int n_bad = 0;
  int dev_k = 0;
  bit dev_abort = 1'b0;
  vec_t vecs[5];

  always @(negedge clk) begin
    if (bus.tx_done_tick) n_done++;
    if (bus.tx_err_tick) n_err++;
    if (bus.tx_done_tick && bus.tx_err_tick) n_bad++;
    if (bus.wr_ps2 && bus.tx_idle && (bus.tx_done_tick || bus.tx_err_tick)) n_bad++;
  end

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    end
  endtask

  // Reference frame as the device sees it: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] frame_model(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return {1'b1, (ones % 2 == 0), d, 1'b0};
  endfunction

  task automatic pulse_wr(input logic [7:0] d);
    @(negedge clk);
    bus.wr_ps2 = 1'b1;
    bus.din    = d;
    @(negedge clk);
    bus.wr_ps2 = 1'b0;
  endtask

  task automatic dev_frame(input int n_pulses, input bit ack, input bit glitch,
                           output logic [10:0] got, output int low_cnt);
    int guard = 0;
    got = '1;
    low_cnt = 0;
    while (ps2c && guard < 200) begin @(negedge clk); guard++; end
    while (!ps2c && low_cnt < 4 * INH) begin low_cnt++; @(negedge clk); end
    repeat (20) @(negedge clk);
    got[0] = ps2d;
    for (int k = 1; k <= n_pulses && !dev_abort; k++) begin
      dev_c_low = 1'b1;
      for (int i = 0; i < HALF && !dev_abort; i++) @(negedge clk);
      dev_c_low = 1'b0;
      dev_k = k;
      for (int i = 0; i < HALF && !dev_abort; i++) begin
        if (glitch && k >= 2 && k <= 8) begin
          if (i == HALF / 4) dev_c_low = 1'b1;
          if (i == HALF / 4 + 3) dev_c_low = 1'b0;
        end
        if (i == HALF / 2) begin
          if (k <= 10) got[k] = ps2d;
          if (k == 10 && ack) dev_d_low = 1'b1;
          if (k == 12) dev_d_low = 1'b0;
        end
        @(negedge clk);
      end
    end
    dev_c_low = 1'b0;
    dev_d_low = 1'b0;
  endtask

  task automatic run_frame(input string tag, input logic [7:0] d, input bit ack, input bit glitch,
                           input logic [10:0] exp_frame, input bit exp_done);
    int d0;
    int e0;
    int low;
    int g;
    logic [10:0] got;
    d0 = n_done;
    e0 = n_err;
    dev_k = 0;
    check({tag, "_idle_before"}, int'(bus.tx_idle), 1);
    pulse_wr(d);
    check({tag, "_idle_drop"}, int'(bus.tx_idle), 0);
    if (glitch) begin
      fork
        dev_frame(12, ack, 1'b1, got, low);
        begin
          for (int w = 0; w < 20000 && dev_k < 3; w++) @(negedge clk);
          check({tag, "_reach_data"}, int'(dev_k >= 3), 1);
          pulse_wr(8'h00);
          check({tag, "_busy_on_ignored_wr"}, int'(bus.tx_idle), 0);
        end
      join
    end else begin
      dev_frame(12, ack, 1'b0, got, low);
    end
    g = 0;
    while (!bus.tx_idle && g < 3000) begin @(negedge clk); g++; end
    check({tag, "_idle_after"}, int'(bus.tx_idle), 1);
    repeat (3) @(negedge clk);
    check({tag, "_rts_low_cycles"}, low, INH);
    check({tag, "_frame_on_wire"}, int'(got), int'(exp_frame));
    check({tag, "_done_ticks"}, n_done - d0, exp_done ? 1 : 0);
    check({tag, "_err_ticks"}, n_err - e0, exp_done ? 0 : 1);
    check({tag, "_lines_released"}, int'({ps2c, ps2d}), 3);
    if (glitch) begin
      repeat (50) @(negedge clk);
      check({tag, "_no_second_frame"}, int'({bus.tx_idle, ps2c}), 3);
    end
  endtask

  initial begin
    logic [10:0] got;
    logic [7:0]  rd;
    bit          rack;
    int          low;
    int          d0;
    int          e0;

    reset      = 1'b1;
    bus.wr_ps2 = 1'b0;
    bus.din    = 8'h00;
    vecs[0] = '{din: 8'hED, ack: 1'b1, glitch: 1'b0, par: 1'b1, exp_done: 1'b1};
    vecs[1] = '{din: 8'h01, ack: 1'b1, glitch: 1'b0, par: 1'b0, exp_done: 1'b1};
    vecs[2] = '{din: 8'hFF, ack: 1'b1, glitch: 1'b0, par: 1'b1, exp_done: 1'b1};
    vecs[3] = '{din: 8'hA5, ack: 1'b0, glitch: 1'b0, par: 1'b1, exp_done: 1'b0};
    vecs[4] = '{din: 8'h3C, ack: 1'b1, glitch: 1'b1, par: 1'b1, exp_done: 1'b1};

    repeat (5) @(negedge clk);
    check("reset_idle", int'(bus.tx_idle), 1);
    check("reset_done", int'(bus.tx_done_tick), 0);
    check("reset_err", int'(bus.tx_err_tick), 0);
    check("reset_lines", int'({ps2c, ps2d}), 3);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    for (int v = 0; v < 5; v++)
      run_frame($sformatf("vec%0d", v), vecs[v].din, vecs[v].ack, vecs[v].glitch,
                {1'b1, vecs[v].par, vecs[v].din, 1'b0}, vecs[v].exp_done);

    for (int r = 0; r < 4; r++) begin
      rd   = 8'($urandom);
      rack = 1'($urandom_range(0, 1));
      run_frame($sformatf("rand%0d", r), rd, rack, 1'b0, frame_model(rd), rack);
    end

    // Reset in the middle of the data phase
    d0 = n_done;
    e0 = n_err;
    dev_k = 0;
    pulse_wr(8'h00);
    fork
      dev_frame(12, 1'b1, 1'b0, got, low);
      begin
        for (int w = 0; w < 20000 && dev_k < 3; w++) @(negedge clk);
        repeat (5) @(negedge clk);
        check("rst_mid_host_driving", int'(ps2d), 0);
        #2 reset = 1'b1;
        #1 check("rst_mid_lines_z", int'({ps2c, ps2d}), 3);
        dev_abort = 1'b1;
        @(posedge clk);
        #1 check("rst_mid_idle", int'(bus.tx_idle), 1);
      end
    join
    @(negedge clk);
    reset = 1'b0;
    dev_abort = 1'b0;
    repeat (20) @(negedge clk);
    check("rst_mid_no_tick", (n_done - d0) + (n_err - e0), 0);
    check("rst_mid_lines_after", int'({bus.tx_idle, ps2c, ps2d}), 7);

`ifdef PS2_TX_TIMEOUT_EN
    begin
      int n;
      int d1;
      d1 = n_done;
      dev_k = 0;
      pulse_wr(8'h55);
      dev_frame(5, 1'b1, 1'b0, got, low);
      check("tmo_bits_before_stall", int'(got[4:0]), int'(5'b01010));
      n = 0;
      while (!bus.tx_err_tick && n < TMO + 500) begin @(negedge clk); n++; end
      check("tmo_err_seen", int'(bus.tx_err_tick), 1);
      check("tmo_latency_window", int'(n >= TMO - 2 * HALF - 20 && n <= TMO + 20), 1);
      check("tmo_idle_with_err", int'(bus.tx_idle), 1);
      check("tmo_lines_z", int'({ps2c, ps2d}), 3);
      @(negedge clk);
      check("tmo_err_one_cycle", int'(bus.tx_err_tick), 0);
      check("tmo_no_done", n_done - d1, 0);
    end
`endif

    check("tick_overlap", n_bad, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
